// File: rtl/cs_decode_seq.sv
// cs_decode_seq: sequential cyclic-shift + XOR decoder.
// Collects K coded symbols (any order), stores them lifted by a parity bit, then
// produces M recovered symbols, accumulating one column term per cycle from a
// programmable table of rotation masks.
module cs_decode_seq #(
    parameter int unsigned K = 5,
    parameter int unsigned M = 3,
    parameter int unsigned L = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_we_i,
    input  logic [$clog2(M)-1:0] cfg_row_i,
    input  logic [$clog2(K)-1:0] cfg_col_i,
    input  logic [L-1:0]         cfg_mask_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [$clog2(K)-1:0] in_idx_i,
    input  logic [L-2:0]         in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [$clog2(M)-1:0] out_idx_o,
    output logic [L-2:0]         out_data_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int unsigned KW = $clog2(K);
    localparam int unsigned MW = $clog2(M);

    localparam logic [1:0] StCollect = 2'd0;
    localparam logic [1:0] StAcc     = 2'd1;
    localparam logic [1:0] StEmit    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [K-1:0]  rcv_q, rcv_d;
    logic [MW-1:0] r_q, r_d;
    logic [KW-1:0] c_q, c_d;
    logic [L-1:0]  acc_q, acc_d;
    logic          err_q, err_d;
    logic          cap;
    logic          idx_ok;
    logic          cfg_ok;
    logic [L-1:0]  term;

    logic [L-1:0]  lift_q [K];
    logic [L-1:0]  coef_q [M][K];

    // Rotate left inside L bits; s = 0 is the identity.
    function automatic logic [L-1:0] rotl(input logic [L-1:0] x, input int unsigned s);
        logic [L-1:0] res;
        for (int unsigned i = 0; i < L; i++) begin
            res[i] = x[(i + L - s) % L];
        end
        return res;
    endfunction

    assign idx_ok = (32'(in_idx_i) < K);
    assign cfg_ok = (32'(cfg_row_i) < M) && (32'(cfg_col_i) < K);

    // Column term for the current (r, c): XOR of the masked rotations of lift[c].
    always_comb begin
        term = '0;
        for (int unsigned s = 0; s < L; s++) begin
            if (coef_q[r_q][c_q][s]) begin
                term = term ^ rotl(lift_q[c_q], s);
            end
        end
    end

    // Next-state logic for the collect / accumulate / emit sequence.
    always_comb begin
        state_d = state_q;
        rcv_d   = rcv_q;
        r_d     = r_q;
        c_d     = c_q;
        acc_d   = acc_q;
        err_d   = 1'b0;
        cap     = 1'b0;
        case (state_q)
            StCollect: begin
                if (in_valid_i) begin
                    if (idx_ok && !rcv_q[in_idx_i]) begin
                        cap            = 1'b1;
                        rcv_d[in_idx_i] = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (rcv_d == {K{1'b1}}) begin
                    state_d = StAcc;
                    r_d     = '0;
                    c_d     = '0;
                    acc_d   = '0;
                end
            end
            StAcc: begin
                acc_d = acc_q ^ term;
                if (c_q == KW'(K - 1)) begin
                    state_d = StEmit;
                end else begin
                    c_d = c_q + KW'(1);
                end
            end
            StEmit: begin
                if (out_ready_i) begin
                    if (r_q == MW'(M - 1)) begin
                        rcv_d   = '0;
                        r_d     = '0;
                        state_d = StCollect;
                    end else begin
                        r_d     = r_q + MW'(1);
                        c_d     = '0;
                        acc_d   = '0;
                        state_d = StAcc;
                    end
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    // State, captured symbols and mask table; the table is writable only while idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StCollect;
            rcv_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            for (int unsigned c = 0; c < K; c++) begin
                lift_q[c] <= '0;
            end
            for (int unsigned r = 0; r < M; r++) begin
                for (int unsigned c = 0; c < K; c++) begin
                    coef_q[r][c] <= (r == c) ? L'(1) : '0;
                end
            end
        end else begin
            state_q <= state_d;
            rcv_q   <= rcv_d;
            r_q     <= r_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            if (cap) begin
                lift_q[in_idx_i] <= {^in_data_i, in_data_i};
            end
            if (cfg_we_i && !busy_o && cfg_ok) begin
                coef_q[cfg_row_i][cfg_col_i] <= cfg_mask_i;
            end
        end
    end

    // Outputs decode registered state only; nothing passes straight from inputs.
    assign in_ready_o  = (state_q == StCollect);
    assign out_valid_o = (state_q == StEmit);
    assign out_idx_o   = r_q;
    assign out_data_o  = acc_q[L-2:0];
    assign busy_o      = (state_q != StCollect) || (rcv_q != '0);
    assign err_o       = err_q;

endmodule

// File: tb/tb_cs_decode_seq.sv
// Directed self-checking bench for cs_decode_seq (K=5, M=3, L=11).
module tb_cs_decode_seq;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cfg_we_i = 1'b0;
    logic [1:0] cfg_row_i = '0;
    logic [2:0] cfg_col_i = '0;
    logic [10:0] cfg_mask_i = '0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [2:0] in_idx_i = '0;
    logic [9:0] in_data_i = '0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b1;
    logic [1:0] out_idx_o;
    logic [9:0] out_data_o;
    logic       busy_o;
    logic       err_o;

    int total = 0;
    int bad = 0;

    cs_decode_seq #(.K(5), .M(3), .L(11)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_row_i   (cfg_row_i),
        .cfg_col_i   (cfg_col_i),
        .cfg_mask_i  (cfg_mask_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_idx_i    (in_idx_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_idx_o   (out_idx_o),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int idx, input logic [9:0] d);
        in_valid_i = 1'b1;
        in_idx_i   = 3'(idx);
        in_data_i  = d;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic cfg(input int r, input int c, input logic [10:0] m);
        cfg_we_i   = 1'b1;
        cfg_row_i  = 2'(r);
        cfg_col_i  = 3'(c);
        cfg_mask_i = m;
        step();
        cfg_we_i = 1'b0;
    endtask

    // n counts cycles since the last accept / handshake; bounded wait.
    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid_o && n < 100) begin
            step();
            n++;
        end
        check("valid_timeout", 32'(out_valid_o), 1);
    endtask

    task automatic get_rows(input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2,
                            input bit timed, input string tag);
        logic [9:0] e [3];
        int n;
        e = '{e0, e1, e2};
        out_ready_i = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_valid(n);
            if (timed) check({tag, "_gap"}, 32'(n), 6);
            check({tag, "_idx"}, 32'(out_idx_o), 32'(r));
            check({tag, "_data"}, 32'(out_data_o), 32'(e[r]));
            step();
        end
        check({tag, "_ready_back"}, 32'(in_ready_o), 1);
        check({tag, "_idle"}, 32'(busy_o), 0);
    endtask

    initial begin
        int n;
        int errs;
        bit seen;

        step();
        step();
        rst_i = 1'b0;
        #0;
        check("rst_in_ready", 32'(in_ready_o), 1);
        check("rst_out_valid", 32'(out_valid_o), 0);
        check("rst_out_idx", 32'(out_idx_o), 0);
        check("rst_out_data", 32'(out_data_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_err", 32'(err_o), 0);

        // Identity table, timing of outputs.
        send(0, 10'h001);
        send(1, 10'h002);
        send(2, 10'h004);
        send(3, 10'h3FF);
        send(4, 10'h155);
        check("t1_busy", 32'(busy_o), 1);
        check("t1_in_ready", 32'(in_ready_o), 0);
        get_rows(10'h001, 10'h002, 10'h004, 1'b1, "t1");

        // Programmed masks; second write lands with the first accept.
        cfg(0, 0, 11'h001);
        cfg_we_i   = 1'b1;
        cfg_row_i  = 2'd0;
        cfg_col_i  = 3'd3;
        cfg_mask_i = 11'h002;
        send(0, 10'h001);
        cfg_we_i = 1'b0;
        send(1, 10'h002);
        send(2, 10'h004);
        send(3, 10'h001);
        send(4, 10'h000);
        get_rows(10'h002, 10'h002, 10'h004, 1'b1, "t2");
        cfg(0, 3, 11'h000);

        // Out-of-order, duplicate and out-of-range index.
        errs = 0;
        send(4, 10'h0F0); check("t3_err_a", 32'(err_o), 0); errs += int'(err_o);
        send(2, 10'h123); check("t3_err_b", 32'(err_o), 0); errs += int'(err_o);
        send(2, 10'h3AA); check("t3_err_dup", 32'(err_o), 1); errs += int'(err_o);
        send(0, 10'h055); check("t3_err_c", 32'(err_o), 0); errs += int'(err_o);
        send(7, 10'h111); check("t3_err_range", 32'(err_o), 1); errs += int'(err_o);
        send(3, 10'h0AA); check("t3_err_d", 32'(err_o), 0); errs += int'(err_o);
        check("t3_still_collect", 32'(in_ready_o), 1);
        send(1, 10'h2C3); check("t3_err_e", 32'(err_o), 0); errs += int'(err_o);
        check("t3_err_count", 32'(errs), 2);
        get_rows(10'h055, 10'h2C3, 10'h123, 1'b1, "t3");

        // Backpressure on row 1.
        send(0, 10'h111);
        send(1, 10'h222);
        send(2, 10'h333);
        send(3, 10'h044);
        send(4, 10'h055);
        out_ready_i = 1'b1;
        wait_valid(n);
        check("t4_row0", 32'(out_data_o), 32'h111);
        step();
        out_ready_i = 1'b0;
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", 32'(out_valid_o), 1);
            check("t4_hold_idx", 32'(out_idx_o), 1);
            check("t4_hold_data", 32'(out_data_o), 32'h222);
            check("t4_hold_in_ready", 32'(in_ready_o), 0);
            check("t4_hold_busy", 32'(busy_o), 1);
            step();
        end
        out_ready_i = 1'b1;
        check("t4_still_valid", 32'(out_valid_o), 1);
        step();
        wait_valid(n);
        check("t4_row2_idx", 32'(out_idx_o), 2);
        check("t4_row2", 32'(out_data_o), 32'h333);
        step();
        check("t4_ready_back", 32'(in_ready_o), 1);

        // Write while busy is ignored.
        send(0, 10'h0A1);
        cfg(1, 1, 11'h000);
        send(1, 10'h0B2);
        send(2, 10'h0C3);
        send(3, 10'h0D4);
        send(4, 10'h0E5);
        get_rows(10'h0A1, 10'h0B2, 10'h0C3, 1'b1, "t5");

        // Non-identity row 2, then reset in ACC must restore identity.
        cfg(2, 2, 11'h002);
        send(0, 10'h010);
        send(1, 10'h020);
        send(2, 10'h030);
        send(3, 10'h040);
        send(4, 10'h050);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("t6_out_valid", 32'(out_valid_o), 0);
        check("t6_busy", 32'(busy_o), 0);
        check("t6_in_ready", 32'(in_ready_o), 1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | out_valid_o;
        end
        check("t6_no_output", 32'(seen), 0);
        send(0, 10'h001);
        send(1, 10'h0B2);
        send(2, 10'h004);
        send(3, 10'h3FF);
        send(4, 10'h000);
        get_rows(10'h001, 10'h0B2, 10'h004, 1'b1, "t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
